rx_ctrl: RTL
============

Name: rx_ctrl

Overview:
Sequencer for the UART receive shift register. It synchronizes the serial line, detects and qualifies the start bit using the 4x oversampling tick, and issues one get_inp strobe per data bit at mid-bit. It checks the stop bit, reports frame completion or framing error, and clears the shift register at each frame start so it cannot stay misaligned after an error. It sits between the baud tick generator and the RX shift register.

Parameters:
DATA_BITS, 9, data bits per frame, LSB first; must match the shift register width.
OVERSAMPLE, 4, Baud4Tick pulses per bit period; even, >=4.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
Baud4Tick  in  1  oversample tick; every clk cycle it is high counts as one tick
RxD  in  1  raw serial line, idle high, asynchronous
en  in  1  receiver enable
get_inp  out  1  one-cycle strobe; shift register captures rx_bit
rx_bit  out  1  sampled data bit, valid when get_inp=1
dp_clr  out  1  one-cycle clear for the shift register bit counter
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse: valid stop bit received
frame_err  out  1  one-cycle pulse: stop bit sampled low
start_glitch  out  1  one-cycle pulse: start bit rejected

Behaviour:
- Reset (rst=0, async): state=IDLE, tick_cnt=0, bit_cnt=0, sync flops=1, rx_bit=1, all other outputs 0.
- rxd_s: RxD through a 2-flop synchronizer. All decisions use rxd_s. Two cycles of line latency.
- All outputs are registered. Each pulse asserts in the cycle after the clk edge where the qualifying tick is seen, and lasts exactly one cycle.
- HALF = OVERSAMPLE/2.
- State machine:
  - IDLE: if en and tick and rxd_s=0: go to START, tick_cnt=0.
  - START: on each tick, tick_cnt++. On the tick where tick_cnt==HALF-1, evaluate rxd_s:
    - rxd_s=1: pulse start_glitch, go to IDLE.
    - rxd_s=0: pulse dp_clr, go to DATA with tick_cnt=0, bit_cnt=0.
  - DATA: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1: rx_bit=rxd_s, pulse get_inp, tick_cnt=0, bit_cnt++. After the DATA_BITS-th sample, go to STOP.
  - STOP: same OVERSAMPLE-tick spacing, then evaluate rxd_s:
    - rxd_s=1: pulse frame_done, go to IDLE.
    - rxd_s=0: pulse frame_err, go to BREAK.
  - BREAK: stay until a tick with rxd_s=1, then go to IDLE. A low line never produces a new frame.
- Timing: first data sample falls OVERSAMPLE+HALF ticks after start detection; each following sample is OVERSAMPLE ticks later.
- Non-tick cycles: no state change, no counter change.
- en=0 in any state: next clk goes to IDLE, counters cleared, no pulses. en takes priority over a simultaneous tick.
- Exactly DATA_BITS get_inp pulses occur per accepted frame. dp_clr always precedes the first get_inp by at least one cycle.
- frame_done and frame_err are mutually exclusive. No pulse is issued for a frame aborted by en or reset.
- Reset mid-frame: immediate return to IDLE. The next frame is received correctly.
- Counter widths: tick_cnt uses $clog2(OVERSAMPLE) bits; bit_cnt uses $clog2(DATA_BITS+1) bits. Neither wraps: both are compared and cleared explicitly.

Decomposition:
- Shared package rx_pkg: state enum (IDLE, START, DATA, STOP, BREAK) and default constants for DATA_BITS and OVERSAMPLE.
- One sub-module, rx_sync: 2-flop synchronizer with async active-low reset to 1.
- Integration: the shift register's reset is driven by (dp_clr | ~rst).

Test Plan:
- Frame 9'h1A5, LSB first, 4 ticks per bit, stop=1 -> 9 get_inp pulses with rx_bit sequence 1,0,1,0,0,1,0,1,1; then one frame_done; dp_clr once before the first get_inp; busy low afterwards.
- RxD low for 1 tick only -> start_glitch pulse; no dp_clr, no get_inp; state returns to IDLE.
- Frame 9'h0FF with stop bit=0, line then held low for 20 ticks -> 9 get_inp, one frame_err, no frame_done; busy stays high until the line goes high; no spurious start detected.
- en dropped after the 4th data bit -> no further get_inp, no frame pulse, busy=0 next cycle; the following frame 9'h155 is received correctly.
- rst asserted mid-DATA -> all outputs at reset values immediately (async); after release, frame 9'h001 yields rx_bit 1,0,0,0,0,0,0,0,0 and frame_done.
- Back-to-back frames 9'h1A5 then 9'h05A, the second start bit immediately after the stop bit -> two frame_done pulses and 18 get_inp pulses with the correct bits.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and default geometry for the UART receive sequencer.
package rx_pkg;

  localparam int unsigned DATA_BITS_DEF  = 9;
  localparam int unsigned OVERSAMPLE_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (high).
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling strobes and stop check.
// The shift register's own reset is expected to be driven by (dp_clr | ~rst).
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic Baud4Tick,
  input  logic RxD,
  input  logic en,
  output logic get_inp,
  output logic rx_bit,
  output logic dp_clr,
  output logic busy,
  output logic frame_done,
  output logic frame_err,
  output logic start_glitch
);

  localparam int unsigned HALF = OVERSAMPLE / 2;
  localparam int unsigned TW   = $clog2(OVERSAMPLE);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t     state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic          rxd_s;
  logic          tick_ok;
  logic          get_nx, rx_bit_nx, clr_nx, done_nx, err_nx, glitch_nx;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxd_s)
  );

  // en low overrides any tick in the same cycle.
  assign tick_ok = en & Baud4Tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      rx_bit       <= 1'b1;
      get_inp      <= 1'b0;
      dp_clr       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      start_glitch <= 1'b0;
    end else begin
      state        <= state_nx;
      tick_cnt     <= tick_nx;
      bit_cnt      <= bit_nx;
      rx_bit       <= rx_bit_nx;
      get_inp      <= get_nx;
      dp_clr       <= clr_nx;
      busy         <= (state_nx != IDLE);
      frame_done   <= done_nx;
      frame_err    <= err_nx;
      start_glitch <= glitch_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    if (!en) begin
      state_nx = IDLE;
      tick_nx  = '0;
      bit_nx   = '0;
    end else if (Baud4Tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nx = START;
            tick_nx  = '0;
            bit_nx   = '0;
          end
        end
        START: begin
          if (tick_cnt == T_HALF) begin
            tick_nx  = '0;
            bit_nx   = '0;
            state_nx = rxd_s ? IDLE : DATA;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == T_LAST) begin
            tick_nx = '0;
            if (bit_cnt == B_LAST) begin
              state_nx = STOP;
              bit_nx   = '0;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == T_LAST) begin
            tick_nx  = '0;
            state_nx = rxd_s ? IDLE : BREAK;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    get_nx    = tick_ok && (state == DATA)  && (tick_cnt == T_LAST);
    clr_nx    = tick_ok && (state == START) && (tick_cnt == T_HALF) && !rxd_s;
    glitch_nx = tick_ok && (state == START) && (tick_cnt == T_HALF) && rxd_s;
    done_nx   = tick_ok && (state == STOP)  && (tick_cnt == T_LAST) && rxd_s;
    err_nx    = tick_ok && (state == STOP)  && (tick_cnt == T_LAST) && !rxd_s;
    rx_bit_nx = get_nx ? rxd_s : rx_bit;
  end

endmodule
